// File: rtl/pipeline_stage_controller.sv
// Write-enable / valid-bit sequencer for an N-stage in-order core (sequential one-hot or pipelined).
// Performance counters are built only when PIPELINE_STAGE_CONTROLLER_PERF_EN is defined; otherwise tied to 0.
module pipeline_stage_controller #(
  parameter int NUM_STAGES  = 5,
  parameter int PIPELINED   = 1,
  parameter int STALL_STAGE = 2,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  pc_wren,
  output logic [NUM_STAGES-2:0] stage_wren,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  ram_wren,
  output logic                  reg_wren,
  output logic [CNT_WIDTH-1:0]  retired_count,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);
  localparam int N = NUM_STAGES;
  localparam logic [N-1:0] STATE_RST = (PIPELINED != 0) ? '0 : N'(1);

  if (NUM_STAGES < 3) begin : g_bad_stages
    $error("pipeline_stage_controller: NUM_STAGES must be >= 3");
  end
  if (STALL_STAGE < 1 || STALL_STAGE > NUM_STAGES-2) begin : g_bad_stall
    $error("pipeline_stage_controller: STALL_STAGE out of range 1..NUM_STAGES-2");
  end
  if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES-2) begin : g_bad_flush
    $error("pipeline_stage_controller: FLUSH_DEPTH out of range 1..NUM_STAGES-2");
  end

  // state is the one-hot phase in sequential mode and the valid chain in pipelined mode
  logic [N-1:0] state, state_nxt;
  logic         ok, stall_eff, flush_eff;

  assign ok        = run & reset_n;
  assign stall_eff = (PIPELINED != 0) & stall & ~flush;
  assign flush_eff = (PIPELINED != 0) & flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= STATE_RST;
    else if (run)  state <= state_nxt;
  end

  assign stage_valid = state;

  if (PIPELINED != 0) begin : g_pipe
    logic [N-1:0] shifted;
    assign shifted = {state[N-2:0], 1'b1};

    always_comb begin
      state_nxt = shifted;
      for (int i = 0; i < N; i++) begin
        if (flush_eff) begin
          if (i >= 1 && i <= FLUSH_DEPTH) state_nxt[i] = 1'b0;
        end else if (stall_eff) begin
          // frozen front end keeps its instructions; the stall stage takes a bubble
          if (i < STALL_STAGE)       state_nxt[i] = state[i];
          else if (i == STALL_STAGE) state_nxt[i] = 1'b0;
        end
      end
    end

    always_comb begin
      pc_wren = ok & ~stall_eff;
      for (int i = 0; i < N-1; i++)
        stage_wren[i] = ok & ~(stall_eff & (i <= STALL_STAGE-2));
    end

    assign ram_wren = ok & state[N-2];
    assign reg_wren = ok & state[N-1];
  end else begin : g_seq
    assign state_nxt  = {state[N-2:0], state[N-1]};
    // next PC is produced by writeback, so the PC updates on the last phase
    assign pc_wren    = ok & state[N-1];
    assign stage_wren = {(N-1){ok}} & state[N-2:0];
    assign ram_wren   = ok & state[N-2];
    assign reg_wren   = ok & state[N-1];
  end

`ifdef PIPELINE_STAGE_CONTROLLER_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_count <= '0;
      stall_count   <= '0;
      flush_count   <= '0;
    end else if (run) begin
      if (reg_wren)  retired_count <= retired_count + CNT_WIDTH'(1);
      if (stall_eff) stall_count   <= stall_count + CNT_WIDTH'(1);
      if (flush_eff) flush_count   <= flush_count + CNT_WIDTH'(1);
    end
  end
`else
  assign retired_count = '0;
  assign stall_count   = '0;
  assign flush_count   = '0;
`endif

endmodule
